// File: rtl/trap_ctrl.sv
// Machine-mode interrupt entry and mret sequencer. Saves mepc/mcause/mstatus
// through the CSR write port, then redirects fetch to the handler or mepc.
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        exec_valid,
    input  logic [31:0] exec_pc,
    input  logic        mret_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        csr_wr_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic [31:0] mip_o,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SAVE_EPC    = 3'd1,
        SAVE_CAUSE  = 3'd2,
        SAVE_STATUS = 3'd3,
        JUMP        = 3'd4,
        MRET        = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] mip_q, mip_d;
    logic        pend_ext_s, pend_tmr_s, take_s, do_mret_s, vec_s;
    logic [31:0] base_s;
    logic        unused_s;

    assign unused_s = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0], mepc_i[1:0]};

    // Interrupt qualification; only meaningful while IDLE
    always_comb begin
        pend_ext_s = irq_ext & mie_i[11];
        pend_tmr_s = irq_timer & mie_i[7];
        take_s     = (state_q == IDLE) & mstatus_i[3] & exec_valid
                     & (pend_ext_s | pend_tmr_s) & ~mret_i;
        do_mret_s  = (state_q == IDLE) & exec_valid & mret_i;
        vec_s      = VECTORED_EN & (mtvec_i[1:0] == 2'b01);
        base_s     = {mtvec_i[31:2], 2'b00};
        mip_d      = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};
    end

    // Next-state and latched trap context
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            IDLE: begin
                if (take_s) begin
                    state_d = SAVE_EPC;
                    cause_d = pend_ext_s ? 4'd11 : 4'd7;
                    epc_d   = exec_pc;
                end else if (do_mret_s) begin
                    state_d = MRET;
                end else begin
                    state_d = IDLE;
                end
            end
            SAVE_EPC:    state_d = SAVE_CAUSE;
            SAVE_CAUSE:  state_d = SAVE_STATUS;
            SAVE_STATUS: state_d = JUMP;
            JUMP:        state_d = IDLE;
            MRET:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Output decode; stall drops in JUMP/MRET so the redirect is consumed
    always_comb begin
        csr_wr_o      = 1'b0;
        csr_waddr_o   = 12'h000;
        csr_wdata_o   = 32'h0000_0000;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0000_0000;
        stall_o       = take_s | do_mret_s;
        case (state_q)
            SAVE_EPC: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = 12'h341;
                csr_wdata_o = {epc_q[31:2], 2'b00};
                stall_o     = 1'b1;
            end
            SAVE_CAUSE: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = 12'h342;
                csr_wdata_o = {1'b1, 27'd0, cause_q};
                stall_o     = 1'b1;
            end
            SAVE_STATUS: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = 12'h300;
                csr_wdata_o = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
                stall_o     = 1'b1;
            end
            JUMP: begin
                redirect_o    = 1'b1;
                redirect_pc_o = vec_s ? (base_s + {26'd0, cause_q, 2'b00}) : base_s;
            end
            MRET: begin
                csr_wr_o      = 1'b1;
                csr_waddr_o   = 12'h300;
                csr_wdata_o   = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
                redirect_o    = 1'b1;
                redirect_pc_o = {mepc_i[31:2], 2'b00};
            end
            default: begin
                csr_wr_o = 1'b0;
            end
        endcase
    end

    assign mip_o = mip_q;

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cause_q <= 4'd0;
            epc_q   <= 32'd0;
            mip_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            mip_q   <= mip_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized + directed bench for trap_ctrl; expectations come from a
// queue of scheduled trap steps derived from the interrupt/mret rules.
module tb_trap_ctrl;
    localparam bit VEC = 1'b1;
    localparam int K_EPC = 0, K_CAUSE = 1, K_STATUS = 2, K_JUMP = 3, K_MRET = 4;

    logic        clk = 1'b0;
    logic        rst, irq_timer, irq_ext, exec_valid, mret_i;
    logic [31:0] exec_pc, mstatus_i, mie_i, mtvec_i, mepc_i;
    logic        csr_wr_o, stall_o, redirect_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, mip_o, redirect_pc_o;

    always #5 clk = ~clk;

    trap_ctrl #(.VECTORED_EN(VEC)) dut (
        .clk(clk), .rst(rst), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .exec_valid(exec_valid), .exec_pc(exec_pc), .mret_i(mret_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_wr_o(csr_wr_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .mip_o(mip_o), .stall_o(stall_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o)
    );

    typedef struct {
        int         kind;
        logic [3:0] cause;
        logic [31:0] epc;
    } step_t;

    step_t       sq[$];
    logic [43:0] wlog[$];
    logic [31:0] rlog[$];
    logic        m_tmr, m_ext;
    logic        last_stall, last_rd;
    logic [31:0] last_rpc;
    int          checks = 0;
    int          failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at next posedge+1.
    task automatic step();
        logic        e_wr, e_rd, e_stall, pe, pt, busy;
        logic [11:0] e_addr;
        logic [31:0] e_data, e_rpc, base;
        step_t       s, n;
        #4;
        e_wr = 1'b0; e_rd = 1'b0; e_stall = 1'b0;
        e_addr = 12'h000; e_data = 32'h0; e_rpc = 32'h0;
        busy = (sq.size() > 0);
        if (busy) begin
            s = sq[0];
            case (s.kind)
                K_EPC:    begin e_wr = 1'b1; e_addr = 12'h341; e_data = s.epc & 32'hFFFF_FFFC; e_stall = 1'b1; end
                K_CAUSE:  begin e_wr = 1'b1; e_addr = 12'h342; e_data = 32'h8000_0000 | 32'(s.cause); e_stall = 1'b1; end
                K_STATUS: begin
                    e_wr = 1'b1; e_addr = 12'h300; e_stall = 1'b1;
                    e_data = (mstatus_i & ~32'h0000_0088) | ((mstatus_i & 32'h8) != 32'h0 ? 32'h80 : 32'h0);
                end
                K_JUMP: begin
                    e_rd = 1'b1;
                    base = mtvec_i & 32'hFFFF_FFFC;
                    e_rpc = (VEC && (mtvec_i & 32'h3) == 32'h1) ? base + 32'(s.cause) * 32'd4 : base;
                end
                default: begin
                    e_wr = 1'b1; e_addr = 12'h300; e_rd = 1'b1;
                    e_data = (mstatus_i & ~32'h8) | 32'h80 | ((mstatus_i & 32'h80) != 32'h0 ? 32'h8 : 32'h0);
                    e_rpc = mepc_i & 32'hFFFF_FFFC;
                end
            endcase
        end else begin
            pe = irq_ext && mie_i[11];
            pt = irq_timer && mie_i[7];
            if (mstatus_i[3] && exec_valid && (pe || pt) && !mret_i) begin
                e_stall = 1'b1;
                n.cause = pe ? 4'd11 : 4'd7;
                n.epc = exec_pc;
                for (int k = K_EPC; k <= K_JUMP; k++) begin
                    n.kind = k;
                    sq.push_back(n);
                end
            end else if (exec_valid && mret_i) begin
                e_stall = 1'b1;
                n.kind = K_MRET; n.cause = 4'd0; n.epc = 32'd0;
                sq.push_back(n);
            end
        end
        check_val("csr_wr", 32'(csr_wr_o), 32'(e_wr));
        check_val("csr_waddr", 32'(csr_waddr_o), 32'(e_addr));
        check_val("csr_wdata", csr_wdata_o, e_data);
        check_val("redirect", 32'(redirect_o), 32'(e_rd));
        check_val("redirect_pc", redirect_pc_o, e_rpc);
        check_val("stall", 32'(stall_o), 32'(e_stall));
        check_val("mip", mip_o, (m_ext ? 32'h800 : 32'h0) | (m_tmr ? 32'h80 : 32'h0));
        last_stall = stall_o; last_rd = redirect_o; last_rpc = redirect_pc_o;
        if (csr_wr_o) wlog.push_back({csr_waddr_o, csr_wdata_o});
        if (redirect_o) rlog.push_back(redirect_pc_o);
        if (busy) void'(sq.pop_front());
        if (rst) begin
            sq.delete();
            m_tmr = 1'b0; m_ext = 1'b0;
        end else begin
            m_tmr = irq_timer; m_ext = irq_ext;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; exec_valid = 1'b0; mret_i = 1'b0;
        exec_pc = 32'h0; mstatus_i = 32'h0; mie_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0;
    endtask

    initial begin
        quiet();
        m_tmr = 1'b0; m_ext = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        step();
        check_val("rst_stall", 32'(last_stall), 32'd0);
        check_val("rst_rd", 32'(last_rd), 32'd0);
        check_val("rst_wlog", 32'(wlog.size()), 32'd0);

        // Timer entry, non-vectored
        mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h100; irq_timer = 1'b1;
        exec_valid = 1'b1; exec_pc = 32'h2C;
        wlog.delete(); rlog.delete();
        step();
        check_val("tmr_T_stall", 32'(last_stall), 32'd1);
        exec_valid = 1'b0;
        repeat (3) step();
        step();
        check_val("tmr_T4_rd", 32'(last_rd), 32'd1);
        check_val("tmr_T4_stall", 32'(last_stall), 32'd0);
        check_val("tmr_T4_pc", last_rpc, 32'h100);
        check_val("tmr_nwr", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check_val("tmr_epc", 32'(wlog[0]), 32'h2C);
            check_val("tmr_epc_a", 32'(wlog[0][43:32]), 32'h341);
            check_val("tmr_cause", 32'(wlog[1]), 32'h8000_0007);
            check_val("tmr_status", 32'(wlog[2]), 32'h80);
            check_val("tmr_status_a", 32'(wlog[2][43:32]), 32'h300);
        end

        // Vectored entry, ext beats timer
        quiet();
        mstatus_i = 32'h8; mie_i = 32'h880; mtvec_i = 32'h101; irq_timer = 1'b1; irq_ext = 1'b1;
        exec_valid = 1'b1; exec_pc = 32'h40;
        wlog.delete(); rlog.delete();
        step();
        exec_valid = 1'b0;
        repeat (4) step();
        check_val("vec_nwr", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) check_val("vec_cause", 32'(wlog[1]), 32'h8000_000B);
        check_val("vec_nrd", 32'(rlog.size()), 32'd1);
        if (rlog.size() == 1) check_val("vec_pc", rlog[0], 32'h12C);

        // Masking: MIE=0, mie=0, bubble
        for (int m = 0; m < 3; m++) begin
            quiet();
            mstatus_i = (m == 0) ? 32'h0 : 32'h8;
            mie_i = (m == 1) ? 32'h0 : 32'h880;
            exec_valid = (m != 2);
            irq_timer = 1'b1; irq_ext = 1'b1; exec_pc = 32'h80;
            wlog.delete(); rlog.delete();
            step();
            check_val("mask_stall", 32'(last_stall), 32'd0);
            repeat (3) step();
            check_val("mask_nwr", 32'(wlog.size()), 32'd0);
        end

        // mret with a pending interrupt; interrupt taken afterwards from IDLE
        quiet();
        mstatus_i = 32'h80; mepc_i = 32'h2C; mie_i = 32'h80; irq_timer = 1'b1;
        exec_valid = 1'b1; mret_i = 1'b1; exec_pc = 32'h60; mtvec_i = 32'h200;
        wlog.delete(); rlog.delete();
        step();
        check_val("mret_T_stall", 32'(last_stall), 32'd1);
        mret_i = 1'b0; mstatus_i = 32'h88;
        step();
        check_val("mret_rd", 32'(last_rd), 32'd1);
        check_val("mret_pc", last_rpc, 32'h2C);
        check_val("mret_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) check_val("mret_status", 32'(wlog[0]), 32'h88);
        step();
        check_val("mret_then_take", 32'(last_stall), 32'd1);
        exec_valid = 1'b0;
        repeat (4) step();

        // Reset during SAVE_CAUSE
        quiet();
        mstatus_i = 32'h8; mie_i = 32'h80; irq_timer = 1'b1; exec_valid = 1'b1;
        exec_pc = 32'h1000; mtvec_i = 32'h300;
        step();
        exec_valid = 1'b0; irq_timer = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wlog.delete(); rlog.delete();
        repeat (4) step();
        check_val("rstmid_nwr", 32'(wlog.size()), 32'd0);
        check_val("rstmid_nrd", 32'(rlog.size()), 32'd0);
        check_val("rstmid_stall", 32'(last_stall), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            irq_timer  = ($urandom_range(0, 2) == 0);
            irq_ext    = ($urandom_range(0, 3) == 0);
            exec_valid = ($urandom_range(0, 3) != 0);
            mret_i     = ($urandom_range(0, 9) == 0);
            exec_pc    = $urandom;
            mstatus_i  = $urandom | (($urandom_range(0, 3) != 0) ? 32'h8 : 32'h0);
            mie_i      = $urandom;
            mtvec_i    = ($urandom_range(0, 1) == 0) ? (($urandom & 32'hFFFF_FFFC) | 32'h1) : $urandom;
            mepc_i     = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
